// File: rtl/norm_sched.sv
// norm_sched -- frame sequencer wrapped around the 2-stage Normalization pipeline.
//
// Moves one frame of signed filter results through Normalization (A -> temp -> out).
// It tracks a valid bit for each pipeline stage, drives the pipeline stall, and
// presents valid/ready handshakes on both the upstream and downstream sides.
// It also counts pixels and pulses frame_done when the frame is complete.
//
// Optional feature: define NORM_STATS_EN to add per-frame running min/max outputs.
//
// Ports:
//   clk, reset            rising-edge clock; asynchronous active-high reset
//   start, abort          frame start request (accepted only in IDLE); synchronous abort
//   in_valid/in_ready     upstream handshake; in_data is the signed sample
//   norm_a, norm_stall    drive Normalization.A and Normalization.stall
//   norm_out              result from Normalization.out
//   out_valid/out_ready   downstream handshake; out_data = norm_out
//   busy                  high while in RUN or DRAIN
//   frame_done            1-cycle pulse after the last output handshake
//   pix_count             output handshakes completed in the current frame
//   stat_min, stat_max    (NORM_STATS_EN only) running min/max of accepted samples
module norm_sched #(
  parameter int DATA_W       = 22,
  parameter int OUT_W        = 30,
  parameter int FRAME_PIXELS = 65536,
  parameter int CNT_W        = 17
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic signed [DATA_W-1:0] norm_a,
  output logic                     norm_stall,
  input  logic        [OUT_W-1:0]  norm_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic        [OUT_W-1:0]  out_data,
  output logic                     busy,
  output logic                     frame_done,
  output logic        [CNT_W-1:0]  pix_count
`ifdef NORM_STATS_EN
  ,
  output logic signed [DATA_W-1:0] stat_min,
  output logic signed [DATA_W-1:0] stat_max
`endif
);

  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_next;
  logic [1:0]       v;        // v[0] tags Normalization.temp, v[1] tags Normalization.out
  logic [CNT_W-1:0] acc_cnt;
  logic             advance;
  logic             in_hs;
  logic             out_hs;
  logic             start_frame;

  assign norm_a    = in_data;
  assign out_data  = norm_out;
  assign out_valid = v[1];

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    frame_done  = 1'b0;
    in_ready    = 1'b0;
    norm_stall  = 1'b1;
    // The pipeline moves unless a finished result is waiting on downstream.
    advance     = ~(v[1] & ~out_ready);
    start_frame = (state == S_IDLE) & start & ~abort;

    case (state)
      S_RUN: begin
        busy       = 1'b1;
        norm_stall = ~advance;
        in_ready   = advance & (acc_cnt < FRAME_CNT);
      end
      S_DRAIN: begin
        busy       = 1'b1;
        norm_stall = ~advance;
      end
      S_DONE:  frame_done = 1'b1;
      default: ;
    endcase

    in_hs  = in_valid & in_ready;
    out_hs = v[1] & out_ready;

    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (in_hs && acc_cnt == LAST_IDX) state_next = S_DRAIN;
      S_DRAIN: if (out_hs && pix_count == LAST_IDX) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    if (abort) state_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Abort discards whatever Normalization holds by dropping the stage tags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= '0;
    end else if (abort) begin
      v <= '0;
    end else if (advance) begin
      v[1] <= v[0];
      v[0] <= in_hs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_cnt   <= '0;
      pix_count <= '0;
    end else if (abort || start_frame) begin
      acc_cnt   <= '0;
      pix_count <= '0;
    end else begin
      if (in_hs)  acc_cnt   <= acc_cnt + CNT_W'(1);
      if (out_hs) pix_count <= pix_count + CNT_W'(1);
    end
  end

`ifdef NORM_STATS_EN
  // acc_cnt==0 marks the first accepted sample of a frame; values persist
  // after DONE until the next frame's first sample reloads them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_min <= '0;
      stat_max <= '0;
    end else if (in_hs) begin
      if (acc_cnt == '0) begin
        stat_min <= in_data;
        stat_max <= in_data;
      end else begin
        if (in_data < stat_min) stat_min <= in_data;
        if (in_data > stat_max) stat_max <= in_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_norm_sched.sv
// Testbench for norm_sched, using a 4-pixel frame.
// It contains a behavioural Normalization pipeline (two registered stages that
// hold while stalled) that maps A onto 0..255 across the range -510..1530.
// The bench applies a directed vector table and then runs hand-written
// sequences for backpressure, abort and async reset. After that it runs
// randomized frames. A scoreboard built from the per-sample function checks
// ordering, values and per-frame counts.
module tb_norm_sched;
  localparam int DATA_W = 22;
  localparam int OUT_W  = 30;
  localparam int FP     = 4;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic reset, start, abort, in_valid, out_ready;
  logic signed [DATA_W-1:0] in_data;
  logic signed [DATA_W-1:0] norm_a;
  logic norm_stall, in_ready, out_valid, busy, frame_done;
  logic [OUT_W-1:0] norm_out, out_data;
  logic [CNT_W-1:0] pix_count;
`ifdef NORM_STATS_EN
  logic signed [DATA_W-1:0] stat_min, stat_max;
`endif

  norm_sched #(.DATA_W(DATA_W), .OUT_W(OUT_W), .FRAME_PIXELS(FP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .norm_a(norm_a), .norm_stall(norm_stall), .norm_out(norm_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .frame_done(frame_done), .pix_count(pix_count)
`ifdef NORM_STATS_EN
    , .stat_min(stat_min), .stat_max(stat_max)
`endif
  );

  always #5 clk = ~clk;

  function automatic int norm_fn(input int a);
    int t;
    t = a + 510;
    if (t < 0) return 0;
    if (t > 2040) return 255;
    return (t * 255) / 2040;
  endfunction

  // Behavioural Normalization: temp <= A, out <= f(temp), both frozen by stall.
  logic signed [DATA_W-1:0] nm_temp;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nm_temp  <= '0;
      norm_out <= '0;
    end else if (!norm_stall) begin
      nm_temp  <= norm_a;
      norm_out <= OUT_W'(norm_fn(int'(nm_temp)));
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Snapshot of DUT outputs taken at the negedge of each stepped cycle.
  logic s_in_ready, s_out_valid, s_busy, s_done, s_stall;
  logic [OUT_W-1:0] s_out_data;
  logic [CNT_W-1:0] s_pix;

  // Scoreboard and per-frame bookkeeping.
  int sb[$];
  int n_in = 0, n_out = 0;
  bit p_hold = 0, p_abort = 0;
  logic [OUT_W-1:0] p_data = '0;

  task automatic mon();
    if (out_valid && out_ready) begin
      n_out++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_empty: output %0d with no accepted input", out_data);
      end else begin
        tests--;
        chk("out_order", out_data, sb.pop_front());
      end
    end
    if (abort) begin
      sb.delete();
      n_in = 0;
      n_out = 0;
    end else if (in_valid && in_ready) begin
      sb.push_back(norm_fn(int'(in_data)));
      n_in++;
    end
    if (p_hold && !p_abort) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, p_data);
    end
    if (out_valid && !out_ready) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_stall", norm_stall, 1);
    end
    p_hold  = out_valid && !out_ready;
    p_data  = out_data;
    p_abort = abort;
    if (frame_done) begin
      chk("done_pix", pix_count, FP);
      chk("done_nin", n_in, FP);
      chk("done_nout", n_out, FP);
      chk("done_sb_empty", sb.size(), 0);
      n_in = 0;
      n_out = 0;
    end
  endtask

  task automatic step(input logic iv, input int d, input logic ordy, input logic st, input logic ab);
    in_valid  = iv;
    in_data   = DATA_W'(d);
    out_ready = ordy;
    start     = st;
    abort     = ab;
    @(negedge clk);
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_busy      = busy;
    s_done      = frame_done;
    s_stall     = norm_stall;
    s_pix       = pix_count;
    mon();
    @(posedge clk);
    #1;
  endtask

  int fd[FP];

  task automatic run_frame(input bit rnd, input bit spam_start);
    int k;
    bit done_seen;
    logic iv, ordy;
    step(0, 0, 1, 1, 0);
    k = 0;
    done_seen = 0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      iv   = (k < FP) && (!rnd || $urandom_range(0, 3) != 0);
      ordy = !rnd || $urandom_range(0, 2) != 0;
      step(iv, fd[k % FP], ordy, spam_start, 0);
      if (iv && s_in_ready) k++;
      if (s_done) done_seen = 1;
    end
    chk("frame_done_seen", done_seen, 1);
    chk("frame_inputs", k, FP);
  endtask

  typedef struct {
    logic iv; int d; logic ordy; logic st; logic ab;
    logic e_ir; logic e_ov; int e_od; logic e_busy; logic e_done; logic e_stall; int e_pix;
  } vec_t;
  vec_t tv[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int bp_n, k;
    logic ordy;
    reset = 1; start = 0; abort = 0; in_valid = 0; out_ready = 1; in_data = '0;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_stall", norm_stall, 1);
    chk("rst_pix", pix_count, 0);
    @(posedge clk); #1;
    reset = 0;

    // iv d ordy st ab | in_ready out_valid out_data busy done stall pix
    tv.push_back('{0,    0, 1, 1, 0,  0, 0,   0, 0, 0, 1, 0});
    tv.push_back('{1, -510, 1, 0, 0,  1, 0,   0, 1, 0, 0, 0});
    tv.push_back('{1, -510, 1, 0, 0,  1, 0,   0, 1, 0, 0, 0});
    tv.push_back('{1, -510, 1, 0, 0,  1, 1,   0, 1, 0, 0, 0});
    tv.push_back('{1, -510, 1, 0, 0,  1, 1,   0, 1, 0, 0, 1});
    tv.push_back('{1,  999, 1, 0, 0,  0, 1,   0, 1, 0, 0, 2});
    tv.push_back('{1,  999, 1, 0, 0,  0, 1,   0, 1, 0, 0, 3});
    tv.push_back('{0,    0, 1, 0, 0,  0, 0,   0, 0, 1, 1, 4});
    tv.push_back('{0,    0, 1, 1, 0,  0, 0,   0, 0, 0, 1, 4});
    tv.push_back('{1, 1530, 1, 0, 0,  1, 0,   0, 1, 0, 0, 0});
    tv.push_back('{1,  510, 1, 0, 0,  1, 0,   0, 1, 0, 0, 0});
    tv.push_back('{1, -510, 1, 0, 0,  1, 1, 255, 1, 0, 0, 0});
    tv.push_back('{1, 1530, 1, 0, 0,  1, 1, 127, 1, 0, 0, 1});
    tv.push_back('{0,    0, 1, 0, 0,  0, 1,   0, 1, 0, 0, 2});
    tv.push_back('{0,    0, 1, 0, 0,  0, 1, 255, 1, 0, 0, 3});
    tv.push_back('{0,    0, 1, 0, 0,  0, 0,   0, 0, 1, 1, 4});
    tv.push_back('{0,    0, 1, 0, 0,  0, 0,   0, 0, 0, 1, 4});
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].iv, tv[i].d, tv[i].ordy, tv[i].st, tv[i].ab);
      chk($sformatf("v%0d_in_ready", i), s_in_ready, tv[i].e_ir);
      chk($sformatf("v%0d_out_valid", i), s_out_valid, tv[i].e_ov);
      if (tv[i].e_ov) chk($sformatf("v%0d_out_data", i), s_out_data, tv[i].e_od);
      chk($sformatf("v%0d_busy", i), s_busy, tv[i].e_busy);
      chk($sformatf("v%0d_done", i), s_done, tv[i].e_done);
      chk($sformatf("v%0d_stall", i), s_stall, tv[i].e_stall);
      chk($sformatf("v%0d_pix", i), s_pix, tv[i].e_pix);
    end

    // Backpressure: out_ready low for 5 cycles while a result is waiting.
    fd = '{1530, 510, -510, 1020};
    step(0, 0, 1, 1, 0);
    k = 0; bp_n = 0; found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      ordy = !(c >= 3 && c < 8);
      step(k < FP, fd[k % FP], ordy, 0, 0);
      if (s_out_valid && !ordy) begin
        bp_n++;
        chk("bp_snap_stall", s_stall, 1);
        chk("bp_snap_in_ready", s_in_ready, 0);
      end
      if ((k < FP) && s_in_ready) k++;
      if (s_done) found = 1;
    end
    chk("bp_cycles", bp_n, 5);
    chk("bp_done_seen", found, 1);

    // Abort after 2 of 4 inputs, then a fresh frame.
    step(0, 0, 1, 1, 0);
    step(1, 100, 1, 0, 0);
    chk("ab_in1", s_in_ready, 1);
    step(1, 200, 1, 0, 0);
    chk("ab_in2", s_in_ready, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    chk("ab_busy", s_busy, 0);
    chk("ab_out_valid", s_out_valid, 0);
    chk("ab_in_ready", s_in_ready, 0);
    chk("ab_pix", s_pix, 0);
    chk("ab_stall", s_stall, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      chk("ab_no_done", s_done, 0);
      chk("ab_no_valid", s_out_valid, 0);
    end
    fd = '{11, -300, 700, 1400};
    run_frame(0, 0);

    // start and abort together: abort wins.
    step(0, 0, 1, 1, 1);
    step(0, 0, 1, 0, 0);
    chk("sa_busy", s_busy, 0);

    // Async reset between clock edges mid-frame.
    step(0, 0, 1, 1, 0);
    step(1, 300, 1, 0, 0);
    step(1, 400, 1, 0, 0);
    in_valid = 1;
    in_data = DATA_W'(500);
    @(posedge clk); #3;
    reset = 1;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_done", frame_done, 0);
    chk("ar_stall", norm_stall, 1);
    chk("ar_pix", pix_count, 0);
    in_valid = 0;
    sb.delete(); n_in = 0; n_out = 0; p_hold = 0; p_abort = 0;
    @(posedge clk); #1;
    reset = 0;

    // start held high throughout a frame must not restart it.
    fd = '{-100, 0, 100, 200};
    run_frame(0, 1);

`ifdef NORM_STATS_EN
    fd = '{-7, 300, -510, 12};
    run_frame(0, 0);
    chk("stat_min", stat_min, -510);
    chk("stat_max", stat_max, 300);
`endif

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < FP; i++) fd[i] = int'($urandom_range(0, 2200)) - 600;
      run_frame(1, f[0]);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
    chk("end_idle", s_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
